// File: rtl/alu_arbiter_if.sv
// Two-requester ALU access bundle: request channels and response-drain channels.
// Pure wiring; no latency of its own.
// Backpressure: req*_ready and rsp*_ready carry the flow control in each direction.
interface alu_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic        rsp0_zero;
    logic        rsp0_err;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic        rsp1_zero;
    logic        rsp1_err;

    // arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
    );

    // requester side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between two requesters with round-robin arbitration.
// Latency: grant at edge N, registered response visible from cycle N+1.
// Backpressure: a requester is only granted when its one-entry response buffer is empty or draining.

// Combinational 32-bit ALU; unknown control codes produce 0.
module alu (
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result,
    output logic        zero
);
    logic [4:0] shamt;

    assign shamt = operand_b[4:0];

    // operation select
    always_comb begin
        result = 32'h0;
        case (alu_control)
            4'b0000: result = operand_a + operand_b;
            4'b1000: result = operand_a - operand_b;
            4'b0001: result = operand_a << shamt;
            4'b0010: result = {31'h0, $signed(operand_a) < $signed(operand_b)};
            4'b0011: result = {31'h0, operand_a < operand_b};
            4'b0100: result = operand_a ^ operand_b;
            4'b0101: result = operand_a >> shamt;
            4'b0110: result = operand_a | operand_b;
            4'b0111: result = operand_a & operand_b;
            4'b1101: result = $unsigned($signed(operand_a) >>> shamt);
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);
endmodule

module alu_arbiter #(
    parameter bit PRIO_RESET = 1'b0,
    parameter bit CHECK_OPS  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus
);
    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_e;

    localparam ptr_e PTR_INIT = PRIO_RESET ? PTR_REQ1 : PTR_REQ0;

    ptr_e        ptr_q;
    ptr_e        ptr_d;

    logic        elig0;
    logic        elig1;
    logic        grant0;
    logic        grant1;

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    logic        op_legal;
    logic        op_err;
    logic [31:0] cap_result;
    logic        cap_zero;

    logic        rsp0_valid_q;
    logic [31:0] rsp0_result_q;
    logic        rsp0_zero_q;
    logic        rsp0_err_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp1_result_q;
    logic        rsp1_zero_q;
    logic        rsp1_err_q;

    // A requester may issue when its buffer is empty or is being drained this cycle.
    assign elig0 = bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
    assign elig1 = bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);

    // Priority pointer register; reset wins over any same-cycle grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PTR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grant decision and next pointer: lone eligible wins, ties go to the pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        ptr_d  = ptr_q;
        if (elig0 && elig1) begin
            grant0 = (ptr_q == PTR_REQ0);
            grant1 = (ptr_q == PTR_REQ1);
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
        if (grant0) begin
            ptr_d = PTR_REQ1;
        end else if (grant1) begin
            ptr_d = PTR_REQ0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Operand steering: requester 1 only when it holds the grant, otherwise requester 0.
    assign alu_op = grant1 ? bus.req1_op : bus.req0_op;
    assign alu_a  = grant1 ? bus.req1_a  : bus.req0_a;
    assign alu_b  = grant1 ? bus.req1_b  : bus.req0_b;

    alu u_alu (
        .operand_a   (alu_a),
        .operand_b   (alu_b),
        .alu_control (alu_op),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    // Legal control-code decode.
    always_comb begin
        op_legal = 1'b0;
        case (alu_op)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1101: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    // Illegal codes are reported as a zero result with the error flag set.
    always_comb begin
        op_err     = 1'b0;
        cap_result = alu_result;
        cap_zero   = alu_zero;
        if (CHECK_OPS && !op_legal) begin
            op_err     = 1'b1;
            cap_result = 32'h0;
            cap_zero   = 1'b1;
        end
    end

    // Response buffer 0: fill on grant, clear valid on drain, data holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 32'h0;
            rsp0_zero_q   <= 1'b0;
            rsp0_err_q    <= 1'b0;
        end else if (grant0) begin
            rsp0_valid_q  <= 1'b1;
            rsp0_result_q <= cap_result;
            rsp0_zero_q   <= cap_zero;
            rsp0_err_q    <= op_err;
        end else if (rsp0_valid_q && bus.rsp0_ready) begin
            rsp0_valid_q  <= 1'b0;
        end
    end

    // Response buffer 1: same behaviour as buffer 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 32'h0;
            rsp1_zero_q   <= 1'b0;
            rsp1_err_q    <= 1'b0;
        end else if (grant1) begin
            rsp1_valid_q  <= 1'b1;
            rsp1_result_q <= cap_result;
            rsp1_zero_q   <= cap_zero;
            rsp1_err_q    <= op_err;
        end else if (rsp1_valid_q && bus.rsp1_ready) begin
            rsp1_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp0_zero   = rsp0_zero_q;
    assign bus.rsp0_err    = rsp0_err_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp1_zero   = rsp1_zero_q;
    assign bus.rsp1_err    = rsp1_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: per-cycle vector table plus reset and parameter corner cases.
// Inputs driven 1ns after the rising edge, ready checked mid-cycle, state checked after the edge.
// Two instances: default parameters, and PRIO_RESET=1 with CHECK_OPS=0.
module tb_alu_arbiter;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks;
    int   n_errors;

    alu_arbiter_if ia ();
    alu_arbiter_if ib ();

    alu_arbiter #(.PRIO_RESET(1'b0), .CHECK_OPS(1'b1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia));
    alu_arbiter #(.PRIO_RESET(1'b1), .CHECK_OPS(1'b0)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        rr0;
        logic        v1;
        logic [3:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        rr1;
        logic        erdy0;
        logic        erdy1;
        logic        ev0;
        logic [31:0] eres0;
        logic        ez0;
        logic        ee0;
        logic        ev1;
        logic [31:0] eres1;
        logic        ez1;
        logic        ee1;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ia.req0_valid = v.v0;
        ia.req0_op    = v.op0;
        ia.req0_a     = v.a0;
        ia.req0_b     = v.b0;
        ia.rsp0_ready = v.rr0;
        ia.req1_valid = v.v1;
        ia.req1_op    = v.op1;
        ia.req1_a     = v.a1;
        ia.req1_b     = v.b1;
        ia.rsp1_ready = v.rr1;
    endtask

    task automatic idle_b();
        ib.req0_valid = 1'b0;
        ib.req0_op    = 4'h0;
        ib.req0_a     = 32'h0;
        ib.req0_b     = 32'h0;
        ib.rsp0_ready = 1'b1;
        ib.req1_valid = 1'b0;
        ib.req1_op    = 4'h0;
        ib.req1_a     = 32'h0;
        ib.req1_b     = 32'h0;
        ib.rsp1_ready = 1'b1;
    endtask

    // time limit so the run always ends even if something stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        n_checks = 0;
        n_errors = 0;

        //        v0  op0      a0            b0            rr0   v1  op1      a1            b1            rr1   rdy0  rdy1  ev0   eres0         ez0   ee0   ev1   eres1         ez1   ee1
        // test 2: both valid, pointer 0 -> req0 first, then req1
        tbl[0]  = '{1'b1, 4'b1000, 32'h00000005, 32'h00000003, 1'b1, 1'b1, 4'b0100, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1000, 32'h00000005, 32'h00000003, 1'b1, 1'b1, 4'b0100, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        // test 1: lone ADD 5+3
        tbl[2]  = '{1'b1, 4'b0000, 32'h00000005, 32'h00000003, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        // test 3: rsp0 stalled -> req1 granted, rsp0 held; then drain+refill same cycle
        tbl[3]  = '{1'b1, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b1, 4'b0110, 32'h00000001, 32'h00000100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b1, 32'h00000101, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00F000F0, 1'b0, 1'b0, 1'b1, 32'h00000101, 1'b0, 1'b0};
        // test 4: SRA and SLTU on requester 1
        tbl[5]  = '{1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 4'b1101, 32'h80000000, 32'h00000004, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        // test 5: illegal op 1111 with checking on
        tbl[7]  = '{1'b1, 4'b1111, 32'h00000007, 32'h00000009, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        // pointer at 1: tie goes to req1 (SLT -1<1), then req0 (SLL 1<<31)
        tbl[8]  = '{1'b1, 4'b0001, 32'h00000001, 32'h0000001F, 1'b1, 1'b1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'b0001, 32'h00000001, 32'h0000001F, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};
        // tie again: req1 ADD wraps to zero, then req0 SRL
        tbl[10] = '{1'b1, 4'b0101, 32'h80000000, 32'h00000004, 1'b1, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'b0101, 32'h80000000, 32'h00000004, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h08000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        // idle with response held (rsp0_ready=0): nothing changes
        tbl[12] = '{1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h08000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};

        z = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1,
              1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        drive_a(z);
        idle_b();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // reset state
        chk("reset rsp0_valid", {31'h0, ia.rsp0_valid}, 32'h0);
        chk("reset rsp1_valid", {31'h0, ia.rsp1_valid}, 32'h0);
        chk("reset rsp0_result", ia.rsp0_result, 32'h0);
        chk("reset rsp1_result", ia.rsp1_result, 32'h0);
        chk("reset flags", {28'h0, ia.rsp0_zero, ia.rsp0_err, ia.rsp1_zero, ia.rsp1_err}, 32'h0);

        // vector table
        for (int i = 0; i < NV; i++) begin
            drive_a(tbl[i]);
            #3;
            chk($sformatf("v%0d req0_ready", i), {31'h0, ia.req0_ready}, {31'h0, tbl[i].erdy0});
            chk($sformatf("v%0d req1_ready", i), {31'h0, ia.req1_ready}, {31'h0, tbl[i].erdy1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rsp0_valid", i), {31'h0, ia.rsp0_valid}, {31'h0, tbl[i].ev0});
            chk($sformatf("v%0d rsp0_result", i), ia.rsp0_result, tbl[i].eres0);
            chk($sformatf("v%0d rsp0_zero", i), {31'h0, ia.rsp0_zero}, {31'h0, tbl[i].ez0});
            chk($sformatf("v%0d rsp0_err", i), {31'h0, ia.rsp0_err}, {31'h0, tbl[i].ee0});
            chk($sformatf("v%0d rsp1_valid", i), {31'h0, ia.rsp1_valid}, {31'h0, tbl[i].ev1});
            chk($sformatf("v%0d rsp1_result", i), ia.rsp1_result, tbl[i].eres1);
            chk($sformatf("v%0d rsp1_zero", i), {31'h0, ia.rsp1_zero}, {31'h0, tbl[i].ez1});
            chk($sformatf("v%0d rsp1_err", i), {31'h0, ia.rsp1_err}, {31'h0, tbl[i].ee1});
        end

        // reset mid-operation: fill rsp1 (pointer was 1, moves to 0), hold it
        z.v1 = 1'b1; z.op1 = 4'b0000; z.a1 = 32'h2; z.b1 = 32'h3; z.rr1 = 1'b0; z.rr0 = 1'b1;
        drive_a(z);
        @(posedge clk);
        #1;
        chk("pre-reset rsp1_valid", {31'h0, ia.rsp1_valid}, 32'h1);
        chk("pre-reset rsp1_result", ia.rsp1_result, 32'h5);
        // req0 granted in the reset cycle; that grant would move the pointer to 1
        z.v1 = 1'b0; z.v0 = 1'b1; z.op0 = 4'b0000; z.a0 = 32'h1; z.b0 = 32'h1;
        drive_a(z);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        z.v0 = 1'b0;
        drive_a(z);
        chk("rst rsp0_valid", {31'h0, ia.rsp0_valid}, 32'h0);
        chk("rst rsp1_valid", {31'h0, ia.rsp1_valid}, 32'h0);
        chk("rst rsp1_result", ia.rsp1_result, 32'h0);
        @(posedge clk);
        #1;
        chk("dropped grant no rsp0", {31'h0, ia.rsp0_valid}, 32'h0);
        // simultaneous request: pointer must be back at PRIO_RESET=0
        z.v0 = 1'b1; z.op0 = 4'b0110; z.a0 = 32'h0000000A; z.b0 = 32'h00000005;
        z.v1 = 1'b1; z.op1 = 4'b0000; z.a1 = 32'h1; z.b1 = 32'h1; z.rr1 = 1'b1;
        drive_a(z);
        #3;
        chk("post-rst req0_ready", {31'h0, ia.req0_ready}, 32'h1);
        chk("post-rst req1_ready", {31'h0, ia.req1_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst rsp0_result", ia.rsp0_result, 32'h0000000F);
        z.v0 = 1'b0; z.v1 = 1'b0;
        drive_a(z);

        // instance B: PRIO_RESET=1 wins the first tie, illegal op passes unflagged
        ib.req0_valid = 1'b1; ib.req0_op = 4'b1111; ib.req0_a = 32'h7; ib.req0_b = 32'h9;
        ib.req1_valid = 1'b1; ib.req1_op = 4'b0000; ib.req1_a = 32'h1; ib.req1_b = 32'h2;
        #3;
        chk("B tie req0_ready", {31'h0, ib.req0_ready}, 32'h0);
        chk("B tie req1_ready", {31'h0, ib.req1_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("B rsp1_result", ib.rsp1_result, 32'h3);
        ib.req1_valid = 1'b0;
        #3;
        chk("B req0_ready", {31'h0, ib.req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        ib.req0_valid = 1'b0;
        chk("B rsp0_valid", {31'h0, ib.rsp0_valid}, 32'h1);
        chk("B unchecked rsp0_err", {31'h0, ib.rsp0_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit `alu` instance between two requesters (e.g. execute stage and address/branch-compare helper).
- Each requester has a valid/ready request channel and a one-entry registered response buffer with valid/ready drain.
- Round-robin arbitration, at most one ALU operation per cycle, fixed 1-cycle request-to-response latency.
- The block instantiates `alu` internally and drives its ports: operand_a, operand_b, alu_control, result, zero.

Parameters:
- PRIO_RESET, 0: requester holding priority after reset (0 or 1).
- CHECK_OPS, 1: 1 = detect illegal alu_control codes; 0 = pass every code to the ALU unchecked.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  4  ALU control code.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- rsp0_valid  out  1  response buffer 0 holds a result.
- rsp0_ready  in  1  requester 0 consumes the response.
- rsp0_result  out  32  buffered result.
- rsp0_zero  out  1  buffered zero flag.
- rsp0_err  out  1  buffered illegal-op flag.
- req1_*, rsp1_*: identical set for requester 1.

Behaviour:
- Legal codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, OR 0110, AND 0111, SRA 1101.
- Reset (rst_n=0 at a rising edge):
  - rsp*_valid=0, rsp*_result=0, rsp*_zero=0, rsp*_err=0.
  - Priority pointer = PRIO_RESET.
  - Reset mid-operation discards buffered responses and any same-cycle grant.
- Eligibility: eligible_i = reqi_valid & (~rspi_valid | rspi_ready). A same-cycle drain frees the buffer for a new fill.
- Grant:
  - If one requester is eligible, it is granted.
  - If both are eligible, the pointer's requester is granted.
  - reqi_ready = grant_i. It is combinational from valid and buffer state, and at most one ready is high per cycle.
- Requester rule: reqi_valid and its op/operands are held stable until reqi_ready. Ready is never asserted without valid.
- Datapath:
  - The ALU sees the granted requester's op/a/b. With no grant, the ALU inputs are a don't-care and no state changes.
  - On grant_i at edge N, buffer i captures result/zero, and rspi_valid=1 from cycle N+1. Latency is exactly 1 cycle.
- Illegal op (CHECK_OPS=1, code not in the legal list): buffer captures result=0, zero=1, err=1. Otherwise err=0.
- Drain:
  - rspi_valid & rspi_ready with no new grant_i → rspi_valid=0. Data fields hold their last value.
  - While rspi_valid & ~rspi_ready, buffer contents stay stable.
- Priority pointer:
  - After a grant to i, the pointer = 1-i.
  - With no grant, the pointer is unchanged.
  - A lone-eligible grant also moves the pointer.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.
- Responses are never reordered or dropped per requester. Each requester holds at most one outstanding response.

Test Plan:
1. PRIO_RESET=0, only req0_valid with ADD 00000005+00000003, rsp0_ready=1 → req0_ready=1 same cycle; next cycle rsp0_valid=1, result 00000008, zero=0, err=0.
2. Both valid in the cycle after reset: req0 SUB 5-3, req1 XOR 12345678^12345678 → cycle1: req0_ready only, rsp0 = 00000002. Cycle2: req1_ready, rsp1 = 00000000 with zero=1. The pointer alternates 0→1→0.
3. rsp0 holding a result with rsp0_ready=0, req0 and req1 valid → req0_ready=0, req1 granted, rsp0 data unchanged. Then raise rsp0_ready=1 with req0 still valid → req0 accepted in the same cycle as the drain; rsp0_valid stays 1 with the new result.
4. req1 SRA 80000000 by 00000004 → rsp1_result F8000000. req1 SLTU FFFFFFFF,00000001 → 00000000.
5. req0_op=1111 with CHECK_OPS=1 → rsp0_err=1, result 00000000, zero=1. Same stimulus with CHECK_OPS=0 → rsp0_err=0.
6. rst_n=0 for one edge while rsp1_valid=1 and req0 is being granted → after the edge, both rsp*_valid=0 and no response appears for the dropped grant. The pointer equals PRIO_RESET on the next simultaneous request.
